// File: rtl/div.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU; one quotient bit per cycle.
// result_o = {remainder, quotient}, held while start_i stays high in DivEnd.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {DivFree, DivByZero, DivOn, DivEnd} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [64:0] dividend, dividend_nxt;
  logic [31:0] divisor, divisor_nxt;
  logic        neg_q, neg_q_nxt, neg_r, neg_r_nxt;
  logic [63:0] result_nxt;
  logic        ready_nxt;

  logic [31:0] mag1, mag2, quo, rem;
  logic [32:0] diff;
  logic [64:0] step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DivFree;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dividend <= dividend_nxt;
      divisor  <= divisor_nxt;
      neg_q    <= neg_q_nxt;
      neg_r    <= neg_r_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

  always_comb begin
    mag1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    mag2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // Trial subtraction against the upper partial remainder.
    diff = {1'b0, dividend[63:32]} - {1'b0, divisor};
    step = diff[32] ? {dividend[63:0], 1'b0} : {diff[31:0], dividend[31:0], 1'b1};
    quo  = neg_q ? (~step[31:0] + 32'd1) : step[31:0];
    rem  = neg_r ? (~step[64:33] + 32'd1) : step[64:33];

    state_nxt    = state;
    cnt_nxt      = cnt;
    dividend_nxt = dividend;
    divisor_nxt  = divisor;
    neg_q_nxt    = neg_q;
    neg_r_nxt    = neg_r;
    result_nxt   = '0;
    ready_nxt    = 1'b0;

    case (state)
      DivFree: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_nxt = DivByZero;
          end else begin
            state_nxt    = DivOn;
            cnt_nxt      = '0;
            dividend_nxt = {32'd0, mag1, 1'b0};
            divisor_nxt  = mag2;
            neg_q_nxt    = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
            neg_r_nxt    = signed_div_i && opdata1_i[31];
          end
        end
      end
      DivByZero: begin
        state_nxt    = DivEnd;
        dividend_nxt = '0;
        neg_q_nxt    = 1'b0;
        neg_r_nxt    = 1'b0;
      end
      DivOn: begin
        if (annul_i) begin
          state_nxt = DivFree;
        end else if (cnt == 6'd31) begin
          // Final iteration folds in sign correction.
          state_nxt    = DivEnd;
          cnt_nxt      = '0;
          dividend_nxt = {rem, step[32], quo};
        end else begin
          cnt_nxt      = cnt + 6'd1;
          dividend_nxt = step;
        end
      end
      DivEnd: begin
        if (start_i) begin
          ready_nxt  = 1'b1;
          result_nxt = {dividend[64:33], dividend[31:0]};
        end else begin
          state_nxt = DivFree;
        end
      end
      default: state_nxt = DivFree;
    endcase
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: directed vectors, randomized ops vs. arithmetic model,
// annul, mid-operation reset and back-to-back requests.
module tb_div;
  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int total = 0;
  int bad   = 0;

  div dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );

  always #5 clk = ~clk;

  // Truncating division in 64-bit arithmetic; remainder takes the dividend's sign.
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    la = s ? longint'($signed(a)) : longint'({32'd0, a});
    lb = s ? longint'($signed(b)) : longint'({32'd0, b});
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Raises start and waits for ready_o; scrambles operands while busy.
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat);
    @(negedge clk);
    signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!ready_o) begin
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = 1'($urandom);
      end
    end while (!ready_o && lat < 100);
    res = result_o;
  endtask

  task automatic drop_start();
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
    total++; if (result_o !== 64'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic        s [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a [6] = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF, 32'h80000000, 32'd5};
    logic [31:0] b [6] = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFF, 32'd0};
    logic [63:0] e [6] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                           64'h00000000_FFFFFFFF, 64'h00000000_80000000, 64'h0};
    logic [63:0] res;
    int lat, exp_lat;
    for (int i = 0; i < 6; i++) begin
      exp_lat = (b[i] == 32'd0) ? 3 : 34;
      run_div(s[i], a[i], b[i], res, lat);
      total++; if (lat !== exp_lat) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
      total++; if (res !== e[i]) begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, e[i]); end
      repeat (3) @(posedge clk);
      #1;
      total++; if (ready_o !== 1'b1 || result_o !== e[i]) begin
        bad++; $display("FAIL dir%0d_hold ready=%b result=%h exp=1/%h", i, ready_o, result_o, e[i]); end
      drop_start();
      total++; if (ready_o !== 1'b0 || result_o !== 64'd0) begin
        bad++; $display("FAIL dir%0d_drop ready=%b result=%h exp=0/0", i, ready_o, result_o); end
    end
  endtask

  task automatic test_random();
    logic [63:0] res, exp_r;
    logic [31:0] a, b;
    logic s;
    int lat;
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(3))
        0: b = 32'd0;
        1: b = $urandom_range(15);
        2: b = 32'hFFFFFFFF - $urandom_range(3);
        default: b = $urandom;
      endcase
      exp_r = model(s, a, b);
      run_div(s, a, b, res, lat);
      total++; if (res !== exp_r || lat !== ((b == 0) ? 3 : 34)) begin
        bad++; $display("FAIL rand%0d s=%b a=%h b=%h got=%h lat=%0d exp=%h", i, s, a, b, res, lat, exp_r); end
      drop_start();
    end
  endtask

  task automatic test_annul();
    logic [63:0] res;
    int lat, hits;
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); annul_i = 1'b1;
    @(negedge clk); annul_i = 1'b0; start_i = 1'b0;
    hits = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o !== 1'b0 || result_o !== 64'd0) hits++; end
    total++; if (hits !== 0) begin bad++; $display("FAIL annul_quiet got=%0d pulses exp=0", hits); end
    run_div(1'b0, 32'd100, 32'd7, res, lat);
    total++; if (res !== 64'h00000002_0000000E || lat !== 34) begin
      bad++; $display("FAIL annul_restart got=%h lat=%0d exp=%h/34", res, lat, 64'h00000002_0000000E); end
    drop_start();
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat, hits;
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hFFFFFFF9; opdata2_i = 32'd2; start_i = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      bad++; $display("FAIL midreset_out ready=%b result=%h exp=0/0", ready_o, result_o); end
    @(negedge clk); rst = 1'b0; start_i = 1'b0;
    hits = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o !== 1'b0) hits++; end
    total++; if (hits !== 0) begin bad++; $display("FAIL midreset_quiet got=%0d exp=0", hits); end
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, res, lat);
    total++; if (res !== 64'hFFFFFFFF_FFFFFFFD || lat !== 34) begin
      bad++; $display("FAIL midreset_restart got=%h lat=%0d exp=%h/34", res, lat, 64'hFFFFFFFF_FFFFFFFD); end
    drop_start();
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat;
    run_div(1'b0, 32'd100, 32'd7, res, lat);
    total++; if (res !== 64'h00000002_0000000E || lat !== 34) begin
      bad++; $display("FAIL b2b_first got=%h lat=%0d exp=%h/34", res, lat, 64'h00000002_0000000E); end
    drop_start();
    run_div(1'b0, 32'h12345678, 32'h1000, res, lat);
    total++; if (res !== 64'h00000678_00012345 || lat !== 34) begin
      bad++; $display("FAIL b2b_second got=%h lat=%0d exp=%h/34", res, lat, 64'h00000678_00012345); end
    drop_start();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit integer divider for the OpenMIPS core, serving the DIV/DIVU instructions. It sits beside the EX stage. EX raises `start_i` with the operands, stalls the pipeline, and consumes the 64-bit {remainder, quotient} result on `ready_o`. EX then writes that result toward HI/LO through the normal whilo path. The divider is a restoring trial-subtraction engine that produces one quotient bit per cycle.

## Interface
Parameters: none. Widths come from `RegBus` (32) and `DoubleRegBus` (64).

- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  input  32  dividend
- opdata2_i  input  32  divisor
- start_i  input  1  request from EX; held high until EX observes `ready_o`
- annul_i  input  1  cancel in-flight division (e.g. flush); 1 = abort
- result_o  output  64  {remainder[63:32], quotient[31:0]}, registered
- ready_o  output  1  result valid, registered

## Operation
- States: `DivFree`, `DivByZero`, `DivOn`, `DivEnd`. 6-bit iteration counter `cnt`. 65-bit working register `dividend`. 32-bit `divisor`.
- **Reset** (rst=1 at an edge):
  - state = DivFree, cnt = 0
  - ready_o = 0, result_o = 64'h0
  - working registers = 0
  - Reset overrides every state, including mid-operation.
- **DivFree**: ready_o = 0, result_o = 0.
  - If start_i=1 and annul_i=0:
    - opdata2_i = 0 → DivByZero.
    - Otherwise → DivOn, with cnt = 0.
  - Operand latching on entry to DivOn:
    - If signed_div_i=1 and an operand is negative, its two's-complement magnitude is latched.
    - dividend = {32'b0, |opdata1_i|, 1'b0}; divisor = |opdata2_i|.
  - start_i=1 with annul_i=1 → stay in DivFree.
- **DivByZero**: next edge → DivEnd with dividend = 0, so the result is quotient 0, remainder 0.
- **DivOn**:
  - If annul_i=1: → DivFree, all outputs 0.
  - Otherwise, one iteration per edge:
    - diff = dividend[63:32] − divisor (33-bit).
    - If diff is negative: dividend = dividend << 1.
    - Else: dividend = {diff[31:0], dividend[31:0], 1'b1}.
    - cnt++.
  - On the edge performing the 32nd iteration (cnt = 31 before the edge) → DivEnd.
  - Sign correction is applied at that edge (signed mode only):
    - Quotient (dividend[31:0]) is negated iff opdata1[31] ≠ opdata2[31] as latched at start.
    - Remainder (dividend[64:33]) is negated iff the dividend was negative.
  - The latched sign bits are kept for this purpose.
- **DivEnd**:
  - If start_i=1: ready_o = 1, result_o = {remainder, quotient}; remain in DivEnd.
  - If start_i=0: → DivFree, ready_o = 0, result_o = 0.
  - annul_i is ignored in DivEnd and DivByZero.
- **Arithmetic corner case**: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000 (wrap), remainder 0. No exception is raised.
- Operand changes while not in DivFree are ignored.

## Timing
- The start request is sampled at edge E0 (state DivFree).
- Non-zero divisor:
  - Iterations at edges E1..E32; DivEnd is entered after E32.
  - ready_o/result_o are registered at E33 and visible in the cycle after E33.
- Zero divisor: DivByZero after E0, DivEnd after E1, ready_o high after E2.
- ready_o stays high for every cycle start_i is held. It drops at the first edge sampled with start_i = 0.
- Back-to-back operation:
  - A new request may be sampled at the edge after the return to DivFree.
  - Minimum gap is one idle cycle.
- annul_i takes effect at the edge where it is sampled in DivOn. ready_o never pulses for an annulled operation.

## Test plan
- **Unsigned:** DIVU 100 / 7, start held → ready_o rises after E33 with result_o = 64'h00000002_0000000E. Drop start_i → ready_o = 0 and result_o = 0 next edge.
- **Signed:** DIV −7 / 2 (0xFFFFFFF9, 0x00000002) → result_o = 64'hFFFFFFFF_FFFFFFFD. Also DIV 7 / −2 → 64'h00000001_FFFFFFFD.
- **Extremes:**
  - DIVU 0xFFFFFFFF / 1 → 64'h00000000_FFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → 64'h00000000_80000000.
- **Divide by zero:** DIVU 5 / 0 → ready_o high after E2, result_o = 0.
- **Abort:**
  - annul_i = 1 at E10 → state DivFree at E10. ready_o stays 0 through E40 with start_i still high only if it is re-sampled; a new request is then accepted normally.
  - rst = 1 at E20 → all outputs 0 after that edge.
- **Back-to-back:** 100/7 then, after one idle cycle, 0x12345678 / 0x1000 unsigned → second result 64'h00000678_00012345 with identical latency.
